mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single unified `memory` port between instruction fetch (IF, read-only) and the MEM stage (loads/stores).
- Grants at most one requester per cycle and drives the memory's `we`/`input_address`/`mode`/`input_data` from the winner.
- Captures the memory's combinational `output_data` into a registered response delivered one cycle later.
- Prevents IF starvation with a bounded data-streak counter.

Parameters:
- MAX_DM_STREAK, 4, consecutive data grants allowed while IF waits; the next contested cycle goes to IF.
- STREAK_BITS, 3, width of the streak counter; must satisfy 2^STREAK_BITS > MAX_DM_STREAK.

Ports:
- clk  in  1  system clock, all state on posedge
- rst_n  in  1  reset, asynchronous, active-low
- if_req_valid  in  1  fetch request
- if_req_addr  in  64  fetch byte address
- if_req_ready  out  1  fetch granted this cycle (combinational)
- if_flush  in  1  discard any IF response due next cycle
- if_rsp_valid  out  1  fetch data valid (registered)
- if_rsp_data  out  32  instruction word (registered)
- dm_req_valid  in  1  data request
- dm_req_we  in  1  1 = store, 0 = load
- dm_req_addr  in  64  data byte address
- dm_req_mode  in  3  funct3 access mode
- dm_req_wdata  in  64  store data
- dm_req_ready  out  1  data granted this cycle (combinational)
- dm_rsp_valid  out  1  load data or store acknowledge (registered)
- dm_rsp_data  out  64  load result; 0 for store acknowledge
- mem_we  out  1  to memory `we`
- mem_addr  out  64  to memory `input_address`
- mem_mode  out  3  to memory `mode`
- mem_wdata  out  64  to memory `input_data`
- mem_rdata  in  64  from memory `output_data`

Behaviour:
- Reset (async, rst_n=0):
  - if_rsp_valid = 0, dm_rsp_valid = 0, if_rsp_data = 0, dm_rsp_data = 0.
  - streak = 0.
  - A response pending at reset assertion is lost; no response follows release.
- Grant rule, combinational:
  - grant_if = if_req_valid & (~dm_req_valid | streak == MAX_DM_STREAK).
  - grant_dm = dm_req_valid & ~grant_if.
  - if_req_ready = grant_if; dm_req_ready = grant_dm.
  - Never both high in the same cycle.
- Memory drive:
  - On grant_dm: mem_we = dm_req_we, mem_addr = dm_req_addr, mem_mode = dm_req_mode, mem_wdata = dm_req_wdata.
  - On grant_if: mem_we = 0, mem_addr = if_req_addr, mem_mode = 3'b110 (LWU), mem_wdata = 0.
  - No grant: all mem_* outputs 0; mem_we is 0 in particular.
- Response, latency exactly 1 cycle after grant, no backpressure:
  - if_rsp_valid <= grant_if & ~if_flush.
  - if_rsp_data <= mem_rdata[31:0] on grant_if; holds otherwise.
  - dm_rsp_valid <= grant_dm.
  - dm_rsp_data <= dm_req_we ? 0 : mem_rdata on grant_dm; holds otherwise.
  - Each rsp_valid is high for one cycle per grant.
- Streak counter:
  - Increment on grant_dm & if_req_valid, saturating at MAX_DM_STREAK.
  - Clear on grant_if, or on any cycle with if_req_valid = 0.
- Boundaries:
  - if_flush in the grant cycle suppresses if_rsp_valid next cycle but does not cancel the read.
  - if_flush in a non-grant cycle has no effect.
  - A store to address A in cycle N is visible to any read of A granted in cycle N+1 or later.
  - Requesters must hold req signals until they see ready; the arbiter keeps no request queue.
- Address handling: the full 64-bit address is passed to the memory unchanged. Truncation and wrap-around of `address + k` are the memory's responsibility.

Decomposition:
- Shared package gets:
  - MEM_MODE_LWU = 3'b110.
  - Requester index enum REQ_IF/REQ_DM.
  - DWORD_BITS/WORD_BITS from the existing defines header.
- No sub-module is required. Optionally split the streak counter into `streak_counter` (saturating up/clear) if reused by other arbiters.

Test Plan:
- IF only, if_req_addr=0x100, memory word 0x00000013 -> if_req_ready=1 same cycle, mem_mode=110; next cycle if_rsp_valid=1, if_rsp_data=0x00000013.
- Data store then load: SD 0xDEADBEEFCAFEF00D @0x200, next cycle LD @0x200 -> store cycle mem_we=1; load response dm_rsp_data=0xDEADBEEFCAFEF00D; store ack dm_rsp_data=0.
- Contention: both valid continuously, MAX_DM_STREAK=4 -> grant pattern DM,DM,DM,DM,IF, repeating; never both ready; no cycle with mem_we=1 on an IF grant.
- Flush: IF granted @0x104 with if_flush=1 -> next cycle if_rsp_valid=0; following unflushed grant -> if_rsp_valid=1.
- Reset mid-operation: assert rst_n=0 asynchronously one cycle after a DM grant -> dm_rsp_valid drops to 0 immediately and streak=0; after release, the first grant goes to DM if both requesters are valid.
- Idle: no requests for 10 cycles -> all mem_* outputs 0 and both rsp_valid=0 throughout.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   DWORD_BITS / WORD_BITS : data path widths (64-bit dword, 32-bit instruction word)
//   MEM_MODE_LWU           : funct3 code the arbiter drives for instruction fetches
//   req_e                  : requester index (instruction fetch / data memory)
package mem_arbiter_pkg;

  localparam int unsigned DWORD_BITS = 64;
  localparam int unsigned WORD_BITS  = 32;

  localparam logic [2:0] MEM_MODE_LWU = 3'b110;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } req_e;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_streak_counter.sv
// Saturating up-counter with synchronous clear, used to bound how many
// consecutive grants one requester may win while another waits.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one more grant (ignored once saturated)
//   clr        : return to zero; takes priority over inc
//   at_max     : count has reached MAX
module streak_counter #(
  parameter int unsigned MAX  = 4,
  parameter int unsigned BITS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [BITS-1:0] CNT_MAX = BITS'(MAX);

  logic [BITS-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + BITS'(1);
    end
  end

  assign at_max = (count == CNT_MAX);

endmodule : streak_counter

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF,
// read-only) and the MEM stage (loads/stores). One grant per cycle; the
// memory's combinational read data is registered into a response one cycle
// after the grant. Data requests win contested cycles until MAX_DM_STREAK
// consecutive data grants have been made, then IF gets the next one.
//   IF side : if_req_valid/if_req_addr -> if_req_ready (comb);
//             if_flush drops the response due next cycle;
//             if_rsp_valid/if_rsp_data (registered, 32-bit word)
//   DM side : dm_req_valid/we/addr/mode/wdata -> dm_req_ready (comb);
//             dm_rsp_valid/dm_rsp_data (registered; 0 on store ack)
//   Memory  : mem_we/mem_addr/mem_mode/mem_wdata driven by the winner, 0 when idle;
//             mem_rdata is the memory's combinational output
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DM_STREAK = 4,
  parameter int unsigned STREAK_BITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid,
  input  logic [DWORD_BITS-1:0] if_req_addr,
  output logic                  if_req_ready,
  input  logic                  if_flush,
  output logic                  if_rsp_valid,
  output logic [WORD_BITS-1:0]  if_rsp_data,
  input  logic                  dm_req_valid,
  input  logic                  dm_req_we,
  input  logic [DWORD_BITS-1:0] dm_req_addr,
  input  logic [2:0]            dm_req_mode,
  input  logic [DWORD_BITS-1:0] dm_req_wdata,
  output logic                  dm_req_ready,
  output logic                  dm_rsp_valid,
  output logic [DWORD_BITS-1:0] dm_rsp_data,
  output logic                  mem_we,
  output logic [DWORD_BITS-1:0] mem_addr,
  output logic [2:0]            mem_mode,
  output logic [DWORD_BITS-1:0] mem_wdata,
  input  logic [DWORD_BITS-1:0] mem_rdata
);

  logic grant_if;
  logic grant_dm;
  logic streak_at_max;
  req_e winner;

  // Only counts data wins that actually kept IF waiting; any idle IF cycle
  // or IF win restarts the streak.
  streak_counter #(
    .MAX  (MAX_DM_STREAK),
    .BITS (STREAK_BITS)
  ) u_streak (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (grant_dm & if_req_valid),
    .clr    (grant_if | ~if_req_valid),
    .at_max (streak_at_max)
  );

  always_comb begin
    grant_if = if_req_valid & (~dm_req_valid | streak_at_max);
    grant_dm = dm_req_valid & ~grant_if;
    winner   = grant_if ? REQ_IF : REQ_DM;

    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_mode  = '0;
    mem_wdata = '0;
    if (grant_if || grant_dm) begin
      unique case (winner)
        REQ_IF: begin
          mem_addr = if_req_addr;
          mem_mode = MEM_MODE_LWU;
        end
        REQ_DM: begin
          mem_we    = dm_req_we;
          mem_addr  = dm_req_addr;
          mem_mode  = dm_req_mode;
          mem_wdata = dm_req_wdata;
        end
        default: ;
      endcase
    end
  end

  assign if_req_ready = grant_if;
  assign dm_req_ready = grant_dm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rsp_valid <= 1'b0;
      if_rsp_data  <= '0;
      dm_rsp_valid <= 1'b0;
      dm_rsp_data  <= '0;
    end else begin
      // A flushed fetch still performs its read; only the valid is dropped.
      if_rsp_valid <= grant_if & ~if_flush;
      dm_rsp_valid <= grant_dm;
      if (grant_if) begin
        if_rsp_data <= mem_rdata[WORD_BITS-1:0];
      end
      if (grant_dm) begin
        dm_rsp_data <= dm_req_we ? '0 : mem_rdata;
      end
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid;
  logic [63:0] if_req_addr;
  logic        if_req_ready;
  logic        if_flush;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        dm_req_valid;
  logic        dm_req_we;
  logic [63:0] dm_req_addr;
  logic [2:0]  dm_req_mode;
  logic [63:0] dm_req_wdata;
  logic        dm_req_ready;
  logic        dm_rsp_valid;
  logic [63:0] dm_rsp_data;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [2:0]  mem_mode;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int checks;
  int failures;

  mem_arbiter #(
    .MAX_DM_STREAK (4),
    .STREAK_BITS   (3)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_flush     (if_flush),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .dm_req_valid (dm_req_valid),
    .dm_req_we    (dm_req_we),
    .dm_req_addr  (dm_req_addr),
    .dm_req_mode  (dm_req_mode),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_ready (dm_req_ready),
    .dm_rsp_valid (dm_rsp_valid),
    .dm_rsp_data  (dm_rsp_data),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_mode     (mem_mode),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dword memory: combinational read, LWU returns the addressed
  // 32-bit half zero-extended, other modes return the whole dword.
  logic [63:0] mem [0:255];

  always_comb begin
    logic [63:0] d;
    d = mem[mem_addr[10:3]];
    if (mem_mode == 3'b110)
      mem_rdata = {32'h0, mem_addr[2] ? d[63:32] : d[31:0]};
    else
      mem_rdata = d;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;
  end

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    if_flush     = 1'b0;
    dm_req_valid = 1'b0;
    dm_req_we    = 1'b0;
    dm_req_addr  = '0;
    dm_req_mode  = '0;
    dm_req_wdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({if_rsp_valid, dm_rsp_valid} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=00", {if_rsp_valid, dm_rsp_valid});
    end
    checks++;
    if (if_rsp_data !== 32'h0 || dm_rsp_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got if=%h dm=%h exp=0", if_rsp_data, dm_rsp_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_only();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h100;
    #1;
    checks++;
    if ({if_req_ready, dm_req_ready, mem_we, mem_mode} !== {3'b100, 3'b110} || mem_addr !== 64'h100) begin
      failures++;
      $display("FAIL if_grant got rdy=%b%b we=%b mode=%b addr=%h exp rdy=10 we=0 mode=110 addr=100",
               if_req_ready, dm_req_ready, mem_we, mem_mode, mem_addr);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00000013) begin
      failures++;
      $display("FAIL if_rsp got v=%b d=%h exp v=1 d=00000013", if_rsp_valid, if_rsp_data);
    end
    @(negedge clk);
    checks++;
    if (if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL if_rsp_one_cycle got=%b exp=0", if_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b1;
    dm_req_addr  = 64'h200;
    dm_req_mode  = 3'b011;
    dm_req_wdata = 64'hDEADBEEFCAFEF00D;
    #1;
    checks++;
    if (dm_req_ready !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 64'hDEADBEEFCAFEF00D || mem_addr !== 64'h200) begin
      failures++;
      $display("FAIL store_drive got rdy=%b we=%b wdata=%h addr=%h exp rdy=1 we=1 wdata=deadbeefcafef00d addr=200",
               dm_req_ready, mem_we, mem_wdata, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 64'h0) begin
      failures++;
      $display("FAIL store_ack got v=%b d=%h exp v=1 d=0", dm_rsp_valid, dm_rsp_data);
    end
    dm_req_we    = 1'b0;
    dm_req_wdata = 64'h1111;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_wdata !== 64'h1111) begin
      failures++;
      $display("FAIL load_drive got we=%b wdata=%h exp we=0 wdata=1111", mem_we, mem_wdata);
    end
    @(negedge clk);
    dm_req_valid = 1'b0;
    checks++;
    if (dm_rsp_valid !== 1'b1 || dm_rsp_data !== 64'hDEADBEEFCAFEF00D) begin
      failures++;
      $display("FAIL load_rsp got v=%b d=%h exp v=1 d=deadbeefcafef00d", dm_rsp_valid, dm_rsp_data);
    end
    @(negedge clk);
    checks++;
    if (dm_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL dm_rsp_one_cycle got=%b exp=0", dm_rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic exp_if;
    if_req_valid = 1'b1;
    if_req_addr  = 64'h100;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b1;
    dm_req_addr  = 64'h300;
    dm_req_mode  = 3'b011;
    dm_req_wdata = 64'h55;
    for (int i = 0; i < 10; i++) begin
      exp_if = ((i % 5) == 4);
      #1;
      checks++;
      if ({if_req_ready, dm_req_ready} !== {exp_if, ~exp_if}) begin
        failures++;
        $display("FAIL contention_grant cycle=%0d got if=%b dm=%b exp if=%b dm=%b",
                 i, if_req_ready, dm_req_ready, exp_if, ~exp_if);
      end
      checks++;
      if (if_req_ready && (mem_we !== 1'b0 || mem_mode !== 3'b110)) begin
        failures++;
        $display("FAIL contention_if_drive cycle=%0d got we=%b mode=%b exp we=0 mode=110", i, mem_we, mem_mode);
      end
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_flush();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h104;
    if_flush     = 1'b1;
    #1;
    checks++;
    if (if_req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_grant got=%b exp=1", if_req_ready);
    end
    @(negedge clk);
    if_req_addr = 64'h100;
    if_flush    = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL flush_suppress got v=%b d=%h exp v=0 d=aabbccdd", if_rsp_valid, if_rsp_data);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    if_flush     = 1'b1;
    checks++;
    if (if_rsp_valid !== 1'b1 || if_rsp_data !== 32'h00000013) begin
      failures++;
      $display("FAIL flush_resume got v=%b d=%h exp v=1 d=00000013", if_rsp_valid, if_rsp_data);
    end
    @(negedge clk);
    if_flush = 1'b0;
    checks++;
    if (if_rsp_valid !== 1'b0 || if_rsp_data !== 32'h00000013) begin
      failures++;
      $display("FAIL flush_nongrant got v=%b d=%h exp v=0 d=00000013", if_rsp_valid, if_rsp_data);
    end
  endtask

  task automatic test_reset_mid();
    if_req_valid = 1'b1;
    if_req_addr  = 64'h100;
    dm_req_valid = 1'b1;
    dm_req_we    = 1'b0;
    dm_req_addr  = 64'h200;
    dm_req_mode  = 3'b011;
    for (int i = 0; i < 4; i++) @(negedge clk);
    // Four data wins so far: IF is now due, and a DM response is in flight.
    #1;
    checks++;
    if (if_req_ready !== 1'b1 || dm_rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset got if_rdy=%b dm_v=%b exp if_rdy=1 dm_v=1", if_req_ready, dm_rsp_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_rsp_valid !== 1'b0 || if_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got dm_v=%b if_v=%b exp 0 0", dm_rsp_valid, if_rsp_valid);
    end
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL reset_streak_clear got if=%b dm=%b exp if=0 dm=1", if_req_ready, dm_req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({if_req_ready, dm_req_ready} !== 2'b01 || if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got if=%b dm=%b if_v=%b dm_v=%b exp 0 1 0 0",
               if_req_ready, dm_req_ready, if_rsp_valid, dm_rsp_valid);
    end
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_idle();
    idle_inputs();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (mem_we !== 1'b0 || mem_addr !== 64'h0 || mem_mode !== 3'b0 || mem_wdata !== 64'h0 ||
          if_rsp_valid !== 1'b0 || dm_rsp_valid !== 1'b0 || if_req_ready !== 1'b0 || dm_req_ready !== 1'b0) begin
        failures++;
        $display("FAIL idle cycle=%0d got we=%b addr=%h mode=%b wdata=%h if_v=%b dm_v=%b exp all 0",
                 i, mem_we, mem_addr, mem_mode, mem_wdata, if_rsp_valid, dm_rsp_valid);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h20] = 64'hAABBCCDD_00000013;
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_if_only();
    test_store_load();
    test_contention();
    test_flush();
    test_reset_mid();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_arbiter
